// File: rtl/ocp_dma_copy_if.sv
// rtl/ocp_dma_copy_if.sv - OCP single-outstanding-command bus between a copy initiator and a slave
interface ocp_dma_copy_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();
  localparam int BEN_WIDTH = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] MAddr;
  logic [2:0]            MCmd;
  logic [DATA_WIDTH-1:0] MData;
  logic [BEN_WIDTH-1:0]  MByteEn;
  logic                  SCmdAccept;
  logic [DATA_WIDTH-1:0] SData;
  logic [1:0]            SResp;

  modport master (
    output MAddr, MCmd, MData, MByteEn,
    input  SCmdAccept, SData, SResp
  );

  modport slave (
    input  MAddr, MCmd, MData, MByteEn,
    output SCmdAccept, SData, SResp
  );
endinterface

// File: rtl/ocp_dma_copy.sv
// rtl/ocp_dma_copy.sv - OCP initiator copying a block of 32-bit words, one read then one write per word
// Aborts with a sticky error on an error response or when a request/wait state exceeds TIMEOUT cycles.
module ocp_dma_copy #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_src,
  input  logic [ADDR_WIDTH-1:0] i_dst,
  input  logic [CNT_WIDTH-1:0]  i_count,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err,
  ocp_dma_copy_if.master        ocp
);
  localparam int BEN_WIDTH = DATA_WIDTH / 8;

  localparam logic [2:0] OCP_CMD_IDLE  = 3'd0;
  localparam logic [2:0] OCP_CMD_WRITE = 3'd1;
  localparam logic [2:0] OCP_CMD_READ  = 3'd2;
  localparam logic [1:0] OCP_RESP_NULL = 2'b00;
  localparam logic [1:0] OCP_RESP_DVA  = 2'b01;

  localparam logic [15:0]           TMO_LAST  = 16'(TIMEOUT - 1);
  localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(3);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_WAIT,
    S_WR_REQ,
    S_WR_WAIT,
    S_FIN
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] src_q, src_d;
  logic [ADDR_WIDTH-1:0] dst_q, dst_d;
  logic [CNT_WIDTH-1:0]  rem_q, rem_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [15:0]           tmo_q, tmo_d;
  logic                  err_q, err_d;

  logic resp_dva;
  logic resp_bad;
  logic tmo_hit;

  assign resp_dva = (ocp.SResp == OCP_RESP_DVA);
  assign resp_bad = (ocp.SResp != OCP_RESP_NULL) && !resp_dva;
  assign tmo_hit  = (tmo_q == TMO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      data_q  <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

  // Exit conditions are tested before the timeout so a late accept/response still wins.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    data_d  = data_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          src_d   = i_src & WORD_MASK;
          dst_d   = i_dst & WORD_MASK;
          rem_d   = i_count;
          err_d   = 1'b0;
          tmo_d   = '0;
          state_d = (i_count == '0) ? S_FIN : S_RD_REQ;
        end
      end
      S_RD_REQ, S_WR_REQ: begin
        if (ocp.SCmdAccept) begin
          tmo_d   = '0;
          state_d = (state_q == S_RD_REQ) ? S_RD_WAIT : S_WR_WAIT;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = S_FIN;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      S_RD_WAIT: begin
        if (resp_dva) begin
          data_d  = ocp.SData;
          tmo_d   = '0;
          state_d = S_WR_REQ;
        end else if (resp_bad || tmo_hit) begin
          err_d   = 1'b1;
          state_d = S_FIN;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      S_WR_WAIT: begin
        if (resp_dva) begin
          src_d   = src_q + ADDR_WIDTH'(4);
          dst_d   = dst_q + ADDR_WIDTH'(4);
          rem_d   = rem_q - CNT_WIDTH'(1);
          tmo_d   = '0;
          state_d = (rem_q == CNT_WIDTH'(1)) ? S_FIN : S_RD_REQ;
        end else if (resp_bad || tmo_hit) begin
          err_d   = 1'b1;
          state_d = S_FIN;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Bus outputs depend only on registered state, never on the slave inputs.
  assign ocp.MCmd    = (state_q == S_RD_REQ) ? OCP_CMD_READ :
                       (state_q == S_WR_REQ) ? OCP_CMD_WRITE : OCP_CMD_IDLE;
  assign ocp.MAddr   = (state_q == S_WR_REQ) ? dst_q : src_q;
  assign ocp.MData   = data_q;
  assign ocp.MByteEn = (state_q == S_WR_REQ) ? {BEN_WIDTH{1'b1}} : {BEN_WIDTH{1'b0}};

  assign o_busy = (state_q != S_IDLE) && (state_q != S_FIN);
  assign o_done = (state_q == S_FIN);
  assign o_err  = err_q;
endmodule

// File: tb/tb_ocp_dma_copy.sv
// tb/tb_ocp_dma_copy.sv - self-checking bench for ocp_dma_copy with a behavioural OCP memory slave
module tb_ocp_dma_copy;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int CW  = 16;
  localparam int TMO = 10;

  localparam logic [2:0] CMD_IDLE  = 3'd0;
  localparam logic [2:0] CMD_WRITE = 3'd1;
  localparam logic [2:0] CMD_READ  = 3'd2;
  localparam logic [1:0] RESP_NULL = 2'b00;
  localparam logic [1:0] RESP_DVA  = 2'b01;
  localparam logic [1:0] RESP_ERR  = 2'b11;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_start = 1'b0;
  logic [AW-1:0] i_src = '0;
  logic [AW-1:0] i_dst = '0;
  logic [CW-1:0] i_count = '0;
  logic          o_busy;
  logic          o_done;
  logic          o_err;

  ocp_dma_copy_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  ocp_dma_copy #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_src(i_src), .i_dst(i_dst),
    .i_count(i_count), .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .ocp(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural slave: word memory, configurable accept delay, error on the n-th read, or silence.
  logic [31:0] mem [0:1023];
  int          acc_delay = 0;
  int          err_rd = 0;
  bit          no_resp = 1'b0;
  int          rd_num = 0;
  int          wr_num = 0;
  int          wait_cnt = 0;
  bit          pend = 1'b0;
  bit          pend_wr = 1'b0;
  logic [1:0]  pend_resp = RESP_NULL;
  logic [31:0] pend_addr = '0;
  logic [31:0] pend_data = '0;

  initial begin
    bus.SCmdAccept = 1'b0;
    bus.SResp      = RESP_NULL;
    bus.SData      = '0;
  end

  always @(negedge clk) begin
    bus.SCmdAccept = 1'b0;
    bus.SResp      = RESP_NULL;
    if (rst) begin
      pend     = 1'b0;
      wait_cnt = 0;
    end else if (pend) begin
      pend      = 1'b0;
      bus.SResp = pend_resp;
      if (pend_wr) begin
        mem[pend_addr[11:2]] = pend_data;
        wr_num++;
      end else begin
        bus.SData = pend_data;
      end
    end else if (bus.MCmd != CMD_IDLE) begin
      if (wait_cnt < acc_delay) begin
        wait_cnt++;
      end else begin
        wait_cnt       = 0;
        bus.SCmdAccept = 1'b1;
        pend_addr      = bus.MAddr;
        if (bus.MCmd == CMD_WRITE) begin
          pend_wr   = 1'b1;
          pend_resp = RESP_DVA;
          pend_data = bus.MData;
          pend      = 1'b1;
        end else begin
          rd_num++;
          pend_wr   = 1'b0;
          pend_data = mem[bus.MAddr[11:2]];
          pend_resp = (rd_num == err_rd) ? RESP_ERR : RESP_DVA;
          pend      = !no_resp;
        end
      end
    end
  end

  // Transfer model: expected window, abort flag, and the words each write must carry.
  bit          chk_en = 1'b0;
  int          m_start = -100;
  int          m_done = -100;
  bit          m_abort = 1'b0;
  logic [31:0] m_src = '0;
  logic [31:0] m_dst = '0;
  logic [31:0] m_word [0:15];
  bit          exp_busy;

  function automatic int exp_latency(input int cnt);
    int word = 4 + 2 * acc_delay;
    if (cnt == 0) return 1;
    if (no_resp) return 1 + (acc_delay + 1) + TMO;
    if (err_rd >= 1 && err_rd <= cnt) return 1 + (err_rd - 1) * word + (acc_delay + 1) + 1;
    return 1 + cnt * word;
  endfunction

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      exp_busy = (cyc > m_start) && (cyc < m_done);
      check("busy", 32'(o_busy), 32'(exp_busy));
      check("done", 32'(o_done), 32'(cyc == m_done));
      if (cyc > m_start)
        check("err", 32'(o_err), 32'((cyc >= m_done) ? m_abort : 1'b0));
      if (!exp_busy) begin
        check("idle_cmd", 32'(bus.MCmd), 32'(CMD_IDLE));
      end else if (bus.MCmd == CMD_READ) begin
        check("rd_addr", bus.MAddr, m_src + 4 * wr_num);
      end else if (bus.MCmd == CMD_WRITE) begin
        check("wr_addr", bus.MAddr, m_dst + 4 * wr_num);
        check("wr_data", bus.MData, m_word[wr_num]);
        check("wr_ben", 32'(bus.MByteEn), 32'h0000000F);
      end
    end
  end

  int t_start;
  int done_cyc;
  int done_cnt;

  task automatic begin_xfer(input logic [31:0] src, input logic [31:0] dst, input int cnt);
    @(negedge clk);
    i_start = 1'b1;
    i_src   = src;
    i_dst   = dst;
    i_count = cnt[CW-1:0];
    wr_num  = 0;
    rd_num  = 0;
    m_src   = src & ~32'h3;
    m_dst   = dst & ~32'h3;
    m_abort = (cnt > 0) && (no_resp || (err_rd >= 1 && err_rd <= cnt));
    for (int k = 0; k < cnt && k < 16; k++) m_word[k] = mem[src[11:2] + k];
    t_start = cyc;
    m_start = cyc;
    m_done  = cyc + exp_latency(cnt);
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic wait_done();
    done_cyc = -1;
    done_cnt = 0;
    for (int i = 0; i < 400; i++) begin
      if (o_done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
      @(negedge clk);
    end
    if (done_cyc < 0) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: no o_done within 400 cycles");
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[64] = 32'h11111111;
    mem[65] = 32'h22222222;
    mem[66] = 32'h33333333;
    mem[67] = 32'h44444444;

    #1 rst = 1'b1;
    #1;
    check("rst_cmd", 32'(bus.MCmd), 32'(CMD_IDLE));
    check("rst_addr", bus.MAddr, 32'h0);
    check("rst_data", bus.MData, 32'h0);
    check("rst_ben", 32'(bus.MByteEn), 32'h0);
    check("rst_busy", 32'(o_busy), 32'h0);
    check("rst_done", 32'(o_done), 32'h0);
    check("rst_err", 32'(o_err), 32'h0);
    repeat (2) @(negedge clk);
    rst    = 1'b0;
    chk_en = 1'b1;

    // Four-word copy against a zero-wait slave.
    begin_xfer(32'h100, 32'h200, 4);
    wait_done();
    check("t1_latency", done_cyc - t_start, 17);
    check("t1_mem0", mem[128], 32'h11111111);
    check("t1_mem1", mem[129], 32'h22222222);
    check("t1_mem2", mem[130], 32'h33333333);
    check("t1_mem3", mem[131], 32'h44444444);
    check("t1_reads", rd_num, 4);
    check("t1_writes", wr_num, 4);
    check("t1_pulses", done_cnt, 1);
    check("t1_err", 32'(o_err), 32'h0);

    // Zero-length transfer.
    begin_xfer(32'h100, 32'h200, 0);
    wait_done();
    check("t2_latency", done_cyc - t_start, 1);
    check("t2_reads", rd_num, 0);
    check("t2_writes", wr_num, 0);
    check("t2_mem", mem[128], 32'h11111111);

    // Slave holds off every command for three cycles.
    acc_delay = 3;
    begin_xfer(32'h100, 32'h280, 2);
    wait_done();
    check("t3_latency", done_cyc - t_start, 21);
    check("t3_mem0", mem[160], 32'h11111111);
    check("t3_mem1", mem[161], 32'h22222222);
    acc_delay = 0;

    // Error response on the second read.
    err_rd = 2;
    begin_xfer(32'h100, 32'h500, 3);
    wait_done();
    check("t4_latency", done_cyc - t_start, 7);
    check("t4_mem0", mem[320], 32'h11111111);
    check("t4_mem1", mem[321], 32'h0);
    check("t4_writes", wr_num, 1);
    check("t4_reads", rd_num, 2);
    check("t4_pulses", done_cnt, 1);
    check("t4_err", 32'(o_err), 32'h1);
    err_rd = 0;

    // Silent slave: timeout in RD_WAIT.
    no_resp = 1'b1;
    begin_xfer(32'h100, 32'h600, 1);
    wait_done();
    check("t5_latency", done_cyc - t_start, 12);
    check("t5_err", 32'(o_err), 32'h1);
    check("t5_cmd", 32'(bus.MCmd), 32'(CMD_IDLE));
    check("t5_writes", wr_num, 0);
    no_resp = 1'b0;

    // Restart clears the error; low address bits are ignored.
    begin_xfer(32'h10E, 32'h602, 1);
    check("t6_err_cleared", 32'(o_err), 32'h0);
    wait_done();
    check("t6_latency", done_cyc - t_start, 5);
    check("t6_mem", mem[384], 32'h44444444);
    check("t6_err", 32'(o_err), 32'h0);

    // Reset during the second word's write request.
    begin_xfer(32'h100, 32'h300, 4);
    repeat (6) @(negedge clk);
    check("t7_pre_cmd", 32'(bus.MCmd), 32'(CMD_WRITE));
    check("t7_pre_addr", bus.MAddr, 32'h304);
    chk_en = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("t7_rst_cmd", 32'(bus.MCmd), 32'(CMD_IDLE));
    check("t7_rst_addr", bus.MAddr, 32'h0);
    check("t7_rst_data", bus.MData, 32'h0);
    check("t7_rst_ben", 32'(bus.MByteEn), 32'h0);
    check("t7_rst_busy", 32'(o_busy), 32'h0);
    done_cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (o_done) done_cnt++;
    end
    check("t7_no_done", done_cnt, 0);
    m_start = -100;
    m_done  = -100;
    m_abort = 1'b0;
    rst     = 1'b0;
    chk_en  = 1'b1;
    begin_xfer(32'h108, 32'h380, 2);
    wait_done();
    check("t7_latency", done_cyc - t_start, 9);
    check("t7_mem0", mem[224], 32'h33333333);
    check("t7_mem1", mem[225], 32'h44444444);
    check("t7_err", 32'(o_err), 32'h0);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ocp_dma_copy.md
# ocp_dma_copy

OCP bus initiator that copies a block of 32-bit words from a source address to a destination address. It issues one OCP read, then one OCP write, per word. It drives the same single-outstanding-command OCP interface that the behavioural `memory` model and other OCP slaves implement, and sits between a control source (testbench or CPU-side register block) and an OCP slave. One transfer runs at a time, with per-command response timeout and error reporting.

## Interface
Parameters:
- `CNT_WIDTH`, 16, width of the word-count input and internal remaining-count register.
- `TIMEOUT`, 255, maximum cycles spent in any request or wait state before aborting; legal range 1..65535.

Ports:
- `clk` in 1: single clock, all state updates on rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `i_start` in 1: start pulse, sampled only in IDLE.
- `i_src` in `ADDR_WIDTH`: source byte address; bits [1:0] ignored (forced 0).
- `i_dst` in `ADDR_WIDTH`: destination byte address; bits [1:0] ignored.
- `i_count` in `CNT_WIDTH`: number of words to copy.
- `o_busy` out 1: transfer in progress.
- `o_done` out 1: one-cycle completion pulse, on success or abort.
- `o_err` out 1: sticky abort flag, cleared by the next accepted start.
- `o_MAddr` out `ADDR_WIDTH`: OCP address.
- `o_MCmd` out 3: OCP command (`OCP_CMD_IDLE`/`OCP_CMD_READ`/`OCP_CMD_WRITE`).
- `o_MData` out `DATA_WIDTH`: OCP write data.
- `o_MByteEn` out `BEN_WIDTH`: OCP byte enables.
- `i_SCmdAccept` in 1: slave accepts the current command.
- `i_SData` in `DATA_WIDTH`: slave read data.
- `i_SResp` in 2: slave response (`OCP_RESP_NULL`, `OCP_RESP_DVA`, any other value is an error).

## Operation
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, FIN.
- IDLE: `o_busy`=0. On `i_start`=1:
  - Latch `i_src`, `i_dst`, `i_count`, clear `o_err`.
  - If the count is 0, go to FIN. Otherwise go to RD_REQ.
- RD_REQ: drive `o_MCmd`=READ and `o_MAddr`=src.
  - On `i_SCmdAccept`=1 at the edge, go to RD_WAIT.
  - Command and address are held stable until accepted.
- RD_WAIT: drive `o_MCmd`=IDLE.
  - On `i_SResp`=DVA, latch `i_SData` into the data register and go to WR_REQ.
- WR_REQ: drive `o_MCmd`=WRITE, `o_MAddr`=dst, `o_MData`=data register, `o_MByteEn`=all ones.
  - On accept, go to WR_WAIT.
- WR_WAIT: drive `o_MCmd`=IDLE.
  - On DVA: src+=4, dst+=4, remaining-=1.
  - Then go to RD_REQ if remaining is still nonzero after the decrement; otherwise go to FIN.
- FIN: `o_done`=1 for one cycle, then return to IDLE.
- Error response: in RD_WAIT or WR_WAIT, an `i_SResp` that is neither NULL nor DVA sets `o_err` and goes to FIN. Counters and addresses freeze.
- Timeout: a cycle counter is cleared on entry to each REQ/WAIT state and increments every cycle while the state's exit condition is unmet. On reaching `TIMEOUT`, set `o_err` and go to FIN with `o_MCmd`=IDLE.
- Address arithmetic wraps modulo 2^`ADDR_WIDTH`; no wrap detection.
- `i_start` is ignored in every state except IDLE.
- `o_MAddr`, `o_MData` and `o_MByteEn` are don't-care while `o_MCmd`=IDLE, but are driven from registers (no X).

## Timing
- Reset values while `rst`=1, effective immediately regardless of clock:
  - FSM=IDLE.
  - `o_MCmd`=IDLE, `o_MAddr`=0, `o_MData`=0, `o_MByteEn`=0.
  - `o_busy`=0, `o_done`=0, `o_err`=0.
  - Internal counters are cleared.
- Reset mid-transfer abandons the command without completing it; no `o_done` pulse.
- Start edge at cycle T gives: `o_busy`=1 and the first READ on the bus from cycle T+1.
- Against a zero-wait slave (accept on first cycle, DVA the cycle after accept), each word takes 4 cycles.
- `o_done` is asserted at cycle T+1+4N; `o_busy` deasserts in the same cycle as `o_done` (`o_busy`=0 in FIN).
- Count=0: `o_done` at T+1, no bus traffic, `o_busy` never asserted.
- All FSM outputs are registered or decoded from the state register only; no combinational path from `i_S*` to `o_M*`.
- `i_SResp` is ignored in REQ states, and DVA seen in a REQ state is discarded.
- Timeout and a valid exit condition in the same cycle: the exit condition wins.

## Test plan
- Preload slave words 0x100..0x10C = 11111111, 22222222, 33333333, 44444444. Start src=0x100, dst=0x200, count=4. Required: 0x200..0x20C hold the same values, `o_done` 17 cycles after the start edge, `o_err`=0, exactly 4 READs and 4 WRITEs.
- count=0 with src=0x100, dst=0x200 -> `o_done` one cycle after start, `o_MCmd` stays IDLE, no memory changes.
- Slave delays `i_SCmdAccept` 3 cycles on every command, count=2 -> READ/WRITE held with stable address and data, correct copy, `o_done` at T+1+2*(4+6)=T+21.
- Slave returns an error response (2'b11) on the second read, count=3 -> first word copied, no second write, `o_err`=1, one `o_done` pulse.
- Slave never responds, `TIMEOUT`=10 -> abort 10 cycles into RD_WAIT, `o_err`=1, `o_MCmd`=IDLE. A subsequent start clears `o_err`.
- Assert `rst` during WR_REQ of word 2 -> outputs at reset values immediately, no `o_done`. After reset release, a new start copies correctly.
